// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between NUM_REQ requesters.
//
// A round-robin arbiter grants at most one requester per cycle, steers its
// operands onto the ALU, and captures the ALU result in a single output
// register that is drained over a valid/ready channel tagged with the id of
// the requester that issued the op.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   req_valid / req_ready          per-requester op handshake (valid & ready)
//   req_op1 / req_op2 / req_type   per-requester operands and ALU op
//   alu_op1 / alu_op2 / alu_type   to the ALU (zeros and ALU_ADD when idle)
//   alu_data                       same-cycle ALU result
//   rsp_valid / rsp_ready          result handshake
//   rsp_data / rsp_id              captured result and issuing requester id

package defines;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU
    } alu_op_type;

endpackage

module alu_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0][31:0]        req_op1,
    input  logic [NUM_REQ-1:0][31:0]        req_op2,
    input  defines::alu_op_type             req_type [NUM_REQ],
    output logic [31:0]                     alu_op1,
    output logic [31:0]                     alu_op2,
    output defines::alu_op_type             alu_type,
    input  logic [31:0]                     alu_data,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [31:0]                     rsp_data,
    output logic [ID_W-1:0]                 rsp_id
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e            state_q, state_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic              can_accept;
    logic              gnt_valid;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_type_legal;

    // A full register can still take a new op when it is being drained this cycle.
    assign can_accept = (state_q == StEmpty) || rsp_ready;

    // Round-robin search starting at rr_ptr_q and wrapping to 0.
    always_comb begin : grant_search
        logic [ID_W:0] cand;  // extra bit so ptr + offset cannot overflow before the wrap
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        if (can_accept && !rst) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cand = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
                if (cand >= (ID_W+1)'(NUM_REQ)) begin
                    cand = cand - (ID_W+1)'(NUM_REQ);
                end
                if (!gnt_valid && req_valid[cand[ID_W-1:0]]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand[ID_W-1:0];
                end
            end
        end
    end

    // Ready is only raised for the winner, so it depends on valid.
    always_comb begin
        req_ready = '0;
        if (gnt_valid) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Idle ALU inputs are forced to a known legal op so no X reaches the ALU.
    always_comb begin
        alu_op1  = '0;
        alu_op2  = '0;
        alu_type = defines::ALU_ADD;
        if (gnt_valid) begin
            alu_op1  = req_op1[gnt_idx];
            alu_op2  = req_op2[gnt_idx];
            alu_type = req_type[gnt_idx];
        end
    end

    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        rr_ptr_d   = rr_ptr_q;
        if (gnt_valid) begin
            state_d    = StFull;
            rsp_data_d = alu_data;
            rsp_id_d   = gnt_idx;
            rr_ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end else if (rsp_ready) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEmpty;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign rsp_valid = (state_q == StFull);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

    // An out-of-range op type from a granted requester is a caller bug.
    assign gnt_type_legal = alu_type inside {defines::ALU_ADD, defines::ALU_SUB,
                                             defines::ALU_XOR, defines::ALU_OR,
                                             defines::ALU_AND, defines::ALU_SLL,
                                             defines::ALU_SRL, defines::ALU_SRA,
                                             defines::ALU_SLT, defines::ALU_SLTU};

    granted_type_legal_a: assert property (@(posedge clk) disable iff (rst)
        gnt_valid |-> gnt_type_legal);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_alu_arbiter;
    import defines::*;

    localparam int N = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N-1:0][31:0] req_op1;
    logic [N-1:0][31:0] req_op2;
    alu_op_type         req_type [N];
    logic [31:0]        alu_op1;
    logic [31:0]        alu_op2;
    alu_op_type         alu_type;
    logic [31:0]        alu_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_data;
    logic [0:0]         rsp_id;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input alu_op_type t);
        case (t)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_XOR:  return a ^ b;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    // Stand-in for the real ALU.
    assign alu_data = alu_fn(alu_op1, alu_op2, alu_type);

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .req_type  (req_type),
        .alu_op1   (alu_op1),
        .alu_op2   (alu_op2),
        .alu_type  (alu_type),
        .alu_data  (alu_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the output register as a single slot plus a round-robin pointer.
    bit          m_valid = 1'b0;
    logic [31:0] m_data  = '0;
    int          m_id    = 0;
    int          m_ptr   = 0;
    logic [N-1:0] acc    = '0;

    always @(negedge clk) begin
        int          g;
        logic [N-1:0] er;
        logic [31:0] e1;
        logic [31:0] e2;
        alu_op_type  et;
        g = -1;
        if (!rst && (!m_valid || rsp_ready)) begin
            for (int i = 0; i < N; i++) begin
                if (g < 0 && req_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
            end
        end
        er = '0;
        e1 = '0;
        e2 = '0;
        et = ALU_ADD;
        if (g >= 0) begin
            er[g] = 1'b1;
            e1    = req_op1[g];
            e2    = req_op2[g];
            et    = req_type[g];
        end
        check("req_ready", 32'(req_ready), 32'(er));
        check("alu_op1", alu_op1, e1);
        check("alu_op2", alu_op2, e2);
        check("alu_type", 32'(alu_type), 32'(et));
        check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid) begin
            check("rsp_data", rsp_data, m_data);
            check("rsp_id", 32'(rsp_id), 32'(m_id));
        end
        acc = req_valid & req_ready;
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_id    = 0;
            m_ptr   = 0;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = alu_fn(req_op1[g], req_op2[g], req_type[g]);
            m_id    = g;
            m_ptr   = (g + 1) % N;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
    end

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                           input alu_op_type t);
        req_op1[r]  = a;
        req_op2[r]  = b;
        req_type[r] = t;
    endtask

    logic [31:0] exp_data [4];

    initial begin
        rst         = 1'b1;
        req_valid   = '0;
        req_op1     = '0;
        req_op2     = '0;
        req_type[0] = ALU_ADD;
        req_type[1] = ALU_ADD;
        rsp_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_data", rsp_data, 32'd0);
        check("reset rsp_id", 32'(rsp_id), 32'd0);

        // Single op: 5 + 7
        @(posedge clk); #1;
        set_req(0, 32'd5, 32'd7, ALU_ADD);
        req_valid = 2'b01;
        @(negedge clk);
        check("single req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        check("single rsp_valid", 32'(rsp_valid), 32'd1);
        check("single rsp_data", rsp_data, 32'd12);
        check("single rsp_id", 32'(rsp_id), 32'd0);

        // Contention from a fresh pointer
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        set_req(0, 32'd10, 32'd3, ALU_SUB);
        set_req(1, 32'hF0, 32'h0F, ALU_XOR);
        req_valid = 2'b11;
        @(negedge clk);
        check("contend first grant", 32'(req_ready), 32'd1);
        exp_data[0] = 32'd7;
        exp_data[1] = 32'hFF;
        exp_data[2] = 32'd7;
        exp_data[3] = 32'hFF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("contend rsp_valid", 32'(rsp_valid), 32'd1);
            check("contend rsp_data", rsp_data, exp_data[k]);
            check("contend rsp_id", 32'(rsp_id), 32'(k % 2));
        end

        // Backpressure: register holds op0's result, ptr at 1
        @(posedge clk); #1 rsp_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("stall rsp_data", rsp_data, 32'd7);
            check("stall rsp_id", 32'(rsp_id), 32'd0);
            check("stall req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("release grant", 32'(req_ready), 32'd2);
        check("release rsp_data", rsp_data, 32'd7);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        check("reload rsp_valid", 32'(rsp_valid), 32'd1);
        check("reload rsp_data", rsp_data, 32'hFF);
        check("reload rsp_id", 32'(rsp_id), 32'd1);

        // Fairness: requester 1 alone three times, then both
        @(posedge clk); #1;
        set_req(1, 32'd1, 32'd2, ALU_ADD);
        req_valid = 2'b10;
        repeat (3) begin
            @(negedge clk);
            check("solo grant 1", 32'(req_ready), 32'd2);
        end
        @(posedge clk); #1;
        set_req(0, 32'd100, 32'd23, ALU_ADD);
        req_valid = 2'b11;
        @(negedge clk);
        check("fair grant 0", 32'(req_ready), 32'd1);

        // Reset while full with a pending result
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst pre-edge rsp_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("post-rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("post-rst ptr grant", 32'(req_ready), 32'd1);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        check("post-rst rsp_data", rsp_data, 32'd123);
        check("post-rst rsp_id", 32'(rsp_id), 32'd0);

        // Idle
        @(posedge clk); #1 req_valid = '0;
        repeat (10) begin
            @(negedge clk);
            check("idle alu_op1", alu_op1, 32'd0);
            check("idle alu_op2", alu_op2, 32'd0);
            check("idle alu_type", 32'(alu_type), 32'(ALU_ADD));
            check("idle rsp_valid", 32'(rsp_valid), 32'd0);
        end

        // Random traffic; requesters hold their op until it is accepted
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            for (int r = 0; r < N; r++) begin
                if (!req_valid[r] || acc[r]) begin
                    req_valid[r] = ($urandom_range(0, 2) != 0);
                    set_req(r, $urandom, $urandom, alu_op_type'($urandom_range(0, 9)));
                end
            end
        end
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
